// File: rtl/eval_scheduler_if.sv
// Event scheduler bus: stream input, layer configuration, and the
// evaluation / queue observation outputs of eval_scheduler.
interface eval_scheduler_if #(
  parameter int NUM_OUTPUTS = 10,
  parameter int NUM_LAYERS  = 4,
  parameter int DATA_W      = 64
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                     en;
  logic signed [DATA_W-1:0] input_0;
  logic                     new_input_0;
  logic [NUM_OUTPUTS*LW-1:0] layer_map;
  logic [NUM_OUTPUTS-1:0]   periodic_mask;

  logic signed [DATA_W-1:0] ev_data;
  logic                     ev_has_input;
  logic                     ev_has_tick;
  logic [LW-1:0]            layer;
  logic [NUM_OUTPUTS-1:0]   pacing;
  logic                     busy;
  logic                     q_push;
  logic                     q_push_valid;
  logic                     q_pop;
  logic                     q_pop_valid;
  logic                     overflow;

  modport master (
    output en, input_0, new_input_0, layer_map, periodic_mask,
    input  ev_data, ev_has_input, ev_has_tick, layer, pacing, busy,
           q_push, q_push_valid, q_pop, q_pop_valid, overflow
  );

  modport slave (
    input  en, input_0, new_input_0, layer_map, periodic_mask,
    output ev_data, ev_has_input, ev_has_tick, layer, pacing, busy,
           q_push, q_push_valid, q_pop, q_pop_valid, overflow
  );
endinterface

// File: rtl/eval_scheduler.sv
// Event scheduler: merges input events and periodic ticks into a small
// FIFO, then walks the evaluation layers for one event at a time.
// Optional macro EVAL_SCHED_SKIP_EMPTY_EN: skip layers with no enabled output.
module eval_scheduler #(
  parameter int NUM_OUTPUTS   = 10,
  parameter int NUM_LAYERS    = 4,
  parameter int QUEUE_DEPTH   = 4,
  parameter int PERIOD_CYCLES = 1000,
  parameter int DATA_W        = 64
) (
  input  logic clk,
  input  logic rst,
  eval_scheduler_if.slave bus
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW = $clog2(PERIOD_CYCLES);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int EW = DATA_W + 2;
  localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(QUEUE_DEPTH - 1);
  localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            layer_q, layer_d;
  logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
  logic [EW-1:0]            mem_q [QUEUE_DEPTH];
  logic [PW-1:0]            rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic signed [DATA_W-1:0] ev_data_q;
  logic                     ev_in_q, ev_tick_q, overflow_q;
  logic                     tick, push, push_ok, pop, pop_ok;
  logic [EW-1:0]            push_entry, head_entry;
  logic [NUM_OUTPUTS-1:0]   pacing_o;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign push       = bus.en & (bus.new_input_0 | tick);
  assign pop        = bus.en & (state_q == IDLE);
  assign pop_ok     = pop & (count_q != '0);
  assign push_ok    = push & ((count_q < DEPTH_C) | pop_ok);
  assign push_entry = {bus.new_input_0, tick, bus.new_input_0 ? bus.input_0 : '0};
  assign head_entry = mem_q[rd_ptr_q];

`ifdef EVAL_SCHED_SKIP_EMPTY_EN
  logic [NUM_LAYERS-1:0] head_hits, ev_hits;
  logic                  found;
  logic [LW-1:0]         next_layer;

  function automatic logic [NUM_LAYERS-1:0] layerHits(
    input logic has_in, input logic has_tick,
    input logic [NUM_OUTPUTS*LW-1:0] lmap, input logic [NUM_OUTPUTS-1:0] pmask);
    logic [NUM_LAYERS-1:0] hits;
    hits = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if ((has_tick & pmask[i]) | (has_in & ~pmask[i])) hits[lmap[i*LW +: LW]] = 1'b1;
    end
    return hits;
  endfunction

  assign head_hits = layerHits(head_entry[EW-1], head_entry[EW-2], bus.layer_map, bus.periodic_mask);
  assign ev_hits   = layerHits(ev_in_q, ev_tick_q, bus.layer_map, bus.periodic_mask);
`endif

  // Queue occupancy follows accepted pushes and performed pops.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next FSM state and layer: a pop starts a walk, EVAL steps through layers.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
`ifdef EVAL_SCHED_SKIP_EMPTY_EN
    found      = 1'b0;
    next_layer = '0;
`endif
    if (state_q == IDLE) begin
      if (pop_ok) begin
`ifdef EVAL_SCHED_SKIP_EMPTY_EN
        for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
          if (head_hits[l]) begin
            found      = 1'b1;
            next_layer = LW'(l);
          end
        end
        state_d = found ? EVAL : IDLE;
        layer_d = next_layer;
`else
        state_d = EVAL;
        layer_d = '0;
`endif
      end
    end else if (bus.en) begin
`ifdef EVAL_SCHED_SKIP_EMPTY_EN
      for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
        if (ev_hits[l] && (l > int'(layer_q))) begin
          found      = 1'b1;
          next_layer = LW'(l);
        end
      end
      if (found) layer_d = next_layer;
      else       state_d = IDLE;
`else
      if (layer_q == LAYER_LAST) state_d = IDLE;
      else                       layer_d = layer_q + 1'b1;
`endif
    end
  end

  // Per-output evaluate enables for the active layer of the current event.
  always_comb begin
    pacing_o = '0;
    if (bus.en && (state_q == EVAL)) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        pacing_o[i] = (bus.layer_map[i*LW +: LW] == layer_q) &
                      ((ev_tick_q & bus.periodic_mask[i]) | (ev_in_q & ~bus.periodic_mask[i]));
      end
    end
  end

  // FSM, layer and tick counter registers; all freeze while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      if (bus.en) tick_cnt_q <= tick_cnt_d;
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) mem_q[k] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Latch the popped event and record any dropped push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_in_q    <= 1'b0;
      ev_tick_q  <= 1'b0;
      ev_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop_ok) {ev_in_q, ev_tick_q, ev_data_q} <= head_entry;
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign bus.ev_data      = ev_data_q;
  assign bus.ev_has_input = ev_in_q;
  assign bus.ev_has_tick  = ev_tick_q;
  assign bus.layer        = layer_q;
  assign bus.pacing       = pacing_o;
  assign bus.busy         = (state_q == EVAL);
  assign bus.q_push       = push;
  assign bus.q_push_valid = push_ok;
  assign bus.q_pop        = pop;
  assign bus.q_pop_valid  = pop_ok;
  assign bus.overflow     = overflow_q;
endmodule
